// File: rtl/servo_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_bank
// Description : Multi-channel servo PWM generator. All channels share one
//               frame counter, so every pulse starts in phase. Per-channel
//               widths and the enable mask are clamped on write and
//               double-buffered, and take effect only at a frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_bank #(
    parameter int NUM_CH     = 8,
    parameter int PERIOD     = 2000000,
    parameter int MIN_PW     = 50000,
    parameter int MAX_PW     = 250000,
    parameter int DEFAULT_PW = 150000,
    parameter int ADDR_W     = 5
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              servo_write,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic [NUM_CH-1:0] out,
    output logic              frame_tick
);

    localparam int CNT_W = $clog2(PERIOD);

    localparam logic [ADDR_W-1:0] EN_ADDR  = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(NUM_CH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  PW_DEF   = CNT_W'(DEFAULT_PW);

    // Shared frame counter and the two register banks (pending / active)
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  pend [NUM_CH];
    logic [CNT_W-1:0]  act  [NUM_CH];
    logic [NUM_CH-1:0] pend_en;
    logic [NUM_CH-1:0] act_en;

    logic              wrap;
    logic              wr_en;
    logic [NUM_CH-1:0] wr_ch;
    logic [CNT_W-1:0]  clamped;

    assign wrap  = (cnt == CNT_LAST);
    assign wr_en = servo_write && (PADDR == EN_ADDR);

    // Clamp uses the full 32-bit write data so large values cannot alias
    // into the legal range after truncation.
    assign clamped = (PWDATA < 32'(MIN_PW)) ? CNT_W'(MIN_PW) :
                     (PWDATA > 32'(MAX_PW)) ? CNT_W'(MAX_PW) :
                                              PWDATA[CNT_W-1:0];

    // Decode per-channel write strobes
    always_comb begin
        wr_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ch[i] = servo_write && (PADDR == ADDR_W'(i));
        end
    end

    // Frame counter and frame_tick, which is high during cnt == 0
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + CNT_W'(1);
            frame_tick <= wrap;
        end
    end

    // Width registers: writes land in pend; the boundary copies to act,
    // forwarding a write that coincides with the boundary.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pend[i] <= PW_DEF;
                act[i]  <= PW_DEF;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ch[i]) begin
                    pend[i] <= clamped;
                end
                if (wrap) begin
                    act[i] <= wr_ch[i] ? clamped : pend[i];
                end
            end
        end
    end

    // Enable mask, double-buffered the same way as the widths
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pend_en <= '0;
            act_en  <= '0;
        end else begin
            if (wr_en) begin
                pend_en <= PWDATA[NUM_CH-1:0];
            end
            if (wrap) begin
                act_en <= wr_en ? PWDATA[NUM_CH-1:0] : pend_en;
            end
        end
    end

    // Registered PWM outputs: high while cnt < width, one cycle late
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                out[i] <= act_en[i] & (cnt < act[i]);
            end
        end
    end

    // Read mux: active widths, active enables, live counter, else zero
    always_comb begin
        PRDATA = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (PADDR == ADDR_W'(i)) begin
                PRDATA = 32'(act[i]);
            end
        end
        if (PADDR == EN_ADDR) begin
            PRDATA = 32'(act_en);
        end
        if (PADDR == CNT_ADDR) begin
            PRDATA = 32'(cnt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_pwm_bank
// Description : Self-checking bench for servo_pwm_bank. A frame-level model
//               (phase within frame, per-frame widths/enables) predicts the
//               outputs and read data every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_bank;

    localparam int NUM_CH     = 4;
    localparam int PERIOD     = 100;
    localparam int MIN_PW     = 10;
    localparam int MAX_PW     = 80;
    localparam int DEFAULT_PW = 50;
    localparam int ADDR_W     = 3;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              servo_write;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic [NUM_CH-1:0] out;
    logic              frame_tick;

    servo_pwm_bank #(
        .NUM_CH     (NUM_CH),
        .PERIOD     (PERIOD),
        .MIN_PW     (MIN_PW),
        .MAX_PW     (MAX_PW),
        .DEFAULT_PW (DEFAULT_PW),
        .ADDR_W     (ADDR_W)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .servo_write (servo_write),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .out         (out),
        .frame_tick  (frame_tick)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase within the frame and the per-frame settings
    bit m_valid = 1'b0;
    int m_p;
    int m_pend [NUM_CH];
    int m_act  [NUM_CH];
    int m_pend_en;
    int m_act_en;
    bit m_tick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input logic [31:0] d);
        if (d < 32'(MIN_PW)) return MIN_PW;
        if (d > 32'(MAX_PW)) return MAX_PW;
        return int'(d);
    endfunction

    function automatic logic [31:0] exp_rd(input int addr);
        if (addr < NUM_CH)     return 32'(m_act[addr]);
        if (addr == NUM_CH)    return 32'(m_act_en);
        if (addr == NUM_CH + 1) return 32'(m_p);
        return 32'd0;
    endfunction

    // An enabled channel is high at phases 1..width of the frame it belongs to
    function automatic logic [NUM_CH-1:0] exp_out();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i] = ((m_act_en >> i) & 1) == 1 && m_p >= 1 && m_p <= m_act[i];
        end
        return v;
    endfunction

    // One clock cycle: drive at negedge, check read data, advance, check outputs
    task automatic step(input bit rst, input bit wr, input int addr, input logic [31:0] data);
        PRESET      = rst;
        servo_write = wr;
        PADDR       = ADDR_W'(addr);
        PWDATA      = data;
        #1;
        if (m_valid) chk("prdata", PRDATA, exp_rd(addr));
        @(posedge PCLK);
        if (rst) begin
            m_p = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_pend[i] = DEFAULT_PW;
                m_act[i]  = DEFAULT_PW;
            end
            m_pend_en = 0;
            m_act_en  = 0;
            m_tick    = 1'b0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            if (wr && addr < NUM_CH)  m_pend[addr] = clampv(data);
            if (wr && addr == NUM_CH) m_pend_en = int'(data & 32'hF);
            m_tick = (m_p == PERIOD - 1);
            if (m_tick) begin
                m_act    = m_pend;
                m_act_en = m_pend_en;
            end
            m_p = (m_p + 1) % PERIOD;
        end
        @(negedge PCLK);
        if (m_valid) begin
            chk("out", 32'(out), 32'(exp_out()));
            chk("frame_tick", 32'(frame_tick), 32'(m_tick));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, int'($urandom_range(0, 7)), 32'd0);
    endtask

    // Advance until the model phase reaches target (bounded by one frame)
    task automatic to_phase(input int target);
        for (int k = 0; k < PERIOD && m_p != target; k++) idle(1);
    endtask

    initial begin
        PRESET      = 1'b1;
        servo_write = 1'b0;
        PADDR       = '0;
        PWDATA      = '0;

        step(1'b1, 1'b0, 0, 32'd0);
        step(1'b1, 1'b1, 0, 32'd7);     // write during reset is ignored
        chk("rst_w0", PRDATA, 32'(DEFAULT_PW));

        // Enable all channels in frame 0, then watch two full frames
        step(1'b0, 1'b1, 4, 32'hF);
        idle(250);

        // Clamp low / high on channels 1 and 2
        step(1'b0, 1'b1, 1, 32'd5);
        step(1'b0, 1'b1, 2, 32'd1000);
        idle(220);

        // Mid-pulse write on channel 0
        to_phase(20);
        step(1'b0, 1'b1, 0, 32'd30);
        idle(150);

        // Write on the boundary cycle applies to the very next frame
        to_phase(99);
        step(1'b0, 1'b1, 3, 32'd70);
        idle(120);

        // Mid-frame enable change
        to_phase(40);
        step(1'b0, 1'b1, 4, 32'h5);
        idle(180);

        // Reset mid-pulse, then read back reset values
        to_phase(25);
        step(1'b1, 1'b0, 4, 32'd0);
        step(1'b0, 1'b0, 1, 32'd0);
        step(1'b0, 1'b0, 4, 32'd0);
        idle(30);

        // Randomised traffic, including rare resets and out-of-map writes
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] d;
            case ($urandom_range(0, 3))
                0:       d = 32'($urandom_range(0, 100));
                1:       d = $urandom;
                2:       d = 32'($urandom_range(0, 15));
                default: d = 32'($urandom_range(MIN_PW - 2, MAX_PW + 2));
            endcase
            step($urandom_range(0, 499) == 0, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 7)), d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
